// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - Shared types and constants for the data-memory responder
package dmem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - Single-port byte-enabled word storage, synchronous write, combinational read
// No reset: contents survive a responder reset and start out as all zeros.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           i_clk,
  input  logic                           i_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  input  logic [3:0]                     i_be,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS] = '{default: '0};

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - Data-memory responder: request latch, wait-state FSM, error check
// One request in flight; the response appears WAIT_CYCLES+1 edges after the accept edge.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_be,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);

  dmem_state_t r_state;
  dmem_req_t   r_req;
  logic [3:0]  r_cnt;

  logic        w_err;
  logic        w_ram_we;
  logic [31:0] w_ram_rdata;

  assign w_err    = (r_req.addr[1:0] != 2'b00) || ({1'b0, r_req.addr} >= LIMIT);
  assign w_ram_we = (r_state == WAIT) && (r_cnt == 4'd0) && r_req.we && !w_err;

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (w_ram_we),
    .i_addr (r_req.addr[AW+1:2]),
    .i_wdata(r_req.wdata),
    .i_be   (r_req.be),
    .o_rdata(w_ram_rdata)
  );

  // The counter is loaded with WAIT_CYCLES and the access happens on the edge
  // where it reads zero, so WAIT spans WAIT_CYCLES+1 cycles (one even for zero).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_cnt       <= '0;
      o_req_ready <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_req.we    <= i_req_we;
            r_req.addr  <= i_req_addr;
            r_req.wdata <= i_req_wdata;
            r_req.be    <= i_req_be;
            r_cnt       <= 4'(WAIT_CYCLES);
            o_req_ready <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= w_err;
            o_rsp_rdata <= (r_req.we || w_err) ? 32'd0 : w_ram_rdata;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
